sobel_frame_sequencer: RTL and testbench

Sequences one Sobel edge-detection frame pass. Generates the raster read addresses for the input pixel block RAM, tags every returned pixel with its row/column, tells the 3-row line buffers when to shift, and marks which pixels complete a valid 3×3 window. Sits between the input BRAM and the Sobel gradient datapath. Provides a start/busy/done handshake and a downstream hold.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_seq_tagpipe.sv | 37 +++
 rtl/sobel_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, FSM state encoding and helpers for the Sobel frame sequencer.
package sobel_pkg;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Plain-vector copies of the encoding for legacy logic [2:0] state registers.
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_PRIME = S_PRIME;
  localparam logic [2:0] ST_RUN   = S_RUN;
  localparam logic [2:0] ST_FLUSH = S_FLUSH;
  localparam logic [2:0] ST_DONE  = S_DONE;

  function automatic int interior_count(input int img_w, input int img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

endpackage

// File: rtl/sobel_seq_tagpipe.sv
// sobel_seq_tagpipe: LAT-deep {valid, tag} shift register that tracks BRAM read latency.
module sobel_seq_tagpipe
  import sobel_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [LAT-1:0]   vld;
  logic [TAG_W-1:0] tag [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_tag   = tag[LAT-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: raster BRAM address generator and pixel tagger for one Sobel pass.
// Define SOBEL_SEQ_CONTINUOUS_EN for free-running frames (DONE returns straight to PRIME).
//
// state | meaning
// IDLE  | waiting for start, BRAM disabled
// PRIME | issuing rows 0-1 to fill the line buffers
// RUN   | issuing the remaining rows
// FLUSH | draining BRAM_LAT enabled cycles of tags
// DONE  | one-cycle done pulse
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BRAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     pix_valid,
  output logic [$clog2(IMG_W)-1:0] pix_col,
  output logic [$clog2(IMG_H)-1:0] pix_row,
  output logic                     line_shift,
  output logic                     win_valid
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int TAG_W = ROW_W + COL_W;

  localparam logic [ADDR_W-1:0] PRIME_LAST = ADDR_W'(2 * IMG_W - 1);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [1:0]        FLUSH_INIT = 2'(BRAM_LAT - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        flush_cnt;
  logic              issue;
  logic              tag_adv;
  logic              tag_vld;
  logic [TAG_W-1:0]  tag_out;

  assign issue   = ((state == ST_PRIME) || (state == ST_RUN)) && !hold;
  assign tag_adv = !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_PRIME;
            addr  <= '0;
            col   <= '0;
            row   <= '0;
          end
        end
        ST_PRIME, ST_RUN: begin
          if (issue) begin
            if (addr == FRAME_LAST) begin
              // Counters wrap here so a continuous frame restarts at address 0.
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_INIT;
              addr      <= '0;
              col       <= '0;
              row       <= '0;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
              if ((state == ST_PRIME) && (addr == PRIME_LAST)) state <= ST_RUN;
            end
          end
        end
        ST_FLUSH: begin
          if (!hold) begin
            if (flush_cnt == 2'd0) state <= ST_DONE;
            else flush_cnt <= flush_cnt - 2'd1;
          end
        end
        ST_DONE: begin
`ifdef SOBEL_SEQ_CONTINUOUS_EN
          state <= ST_PRIME;
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sobel_seq_tagpipe #(
    .LAT   (BRAM_LAT),
    .TAG_W (TAG_W)
  ) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (tag_adv),
    .in_valid  (issue),
    .in_tag    ({row, col}),
    .out_valid (tag_vld),
    .out_tag   (tag_out)
  );

  assign {pix_row, pix_col} = tag_out;

  // A held BRAM output is not new data, so the line buffers must not shift on it.
  assign pix_valid  = tag_vld && !hold;
  assign line_shift = pix_valid;
  assign win_valid  = pix_valid && (pix_row >= ROW_W'(2)) && (pix_col >= COL_W'(2));

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign mem_en   = issue;
  assign mem_addr = addr;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: directed checks of an 8x4 frame at BRAM latency 1 and 2.
// Build with SOBEL_SEQ_CONTINUOUS_EN defined to exercise the free-running mode instead.
module tb_sobel_frame_sequencer;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int CW   = 3;
  localparam int RW   = 2;
  localparam int NPIX = 32;
  localparam int NWIN = 12;

  logic clk = 1'b0;
  logic rst_n, start, hold;
  int   sel;
  int   n_assert, n_fail;

  logic          a_busy, a_done, a_mem_en, a_pix_valid, a_line_shift, a_win_valid;
  logic [AW-1:0] a_mem_addr;
  logic [CW-1:0] a_pix_col;
  logic [RW-1:0] a_pix_row;
  logic          b_busy, b_done, b_mem_en, b_pix_valid, b_line_shift, b_win_valid;
  logic [AW-1:0] b_mem_addr;
  logic [CW-1:0] b_pix_col;
  logic [RW-1:0] b_pix_row;
  logic          o_busy, o_done, o_mem_en, o_pix_valid, o_line_shift, o_win_valid;
  logic [AW-1:0] o_mem_addr;
  logic [CW-1:0] o_pix_col;
  logic [RW-1:0] o_pix_row;

  always #5 clk = ~clk;

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BRAM_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(a_busy), .done(a_done), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
    .pix_valid(a_pix_valid), .pix_col(a_pix_col), .pix_row(a_pix_row),
    .line_shift(a_line_shift), .win_valid(a_win_valid)
  );

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BRAM_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(b_busy), .done(b_done), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
    .pix_valid(b_pix_valid), .pix_col(b_pix_col), .pix_row(b_pix_row),
    .line_shift(b_line_shift), .win_valid(b_win_valid)
  );

  assign {o_busy, o_done, o_mem_en, o_mem_addr, o_pix_valid, o_pix_col, o_pix_row, o_line_shift, o_win_valid} =
    (sel == 1) ?
      {b_busy, b_done, b_mem_en, b_mem_addr, b_pix_valid, b_pix_col, b_pix_row, b_line_shift, b_win_valid} :
      {a_busy, a_done, a_mem_en, a_mem_addr, a_pix_valid, a_pix_col, a_pix_row, a_line_shift, a_win_valid};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},       o_busy,       0);
    check({tag, "_done"},       o_done,       0);
    check({tag, "_mem_en"},     o_mem_en,     0);
    check({tag, "_mem_addr"},   o_mem_addr,   0);
    check({tag, "_pix_valid"},  o_pix_valid,  0);
    check({tag, "_pix_col"},    o_pix_col,    0);
    check({tag, "_pix_row"},    o_pix_row,    0);
    check({tag, "_line_shift"}, o_line_shift, 0);
    check({tag, "_win_valid"},  o_win_valid,  0);
  endtask

  // One single-shot frame on the selected DUT. Cycle 0 is the cycle after start is sampled.
  task automatic run_frame(input int lat, input int hold_addr, input int hold_len, input int repulse_at,
                           output int n_iss, output int n_pv, output int n_win, output int t_done);
    int exp_addr, nh, hold_left, tag;
    bit hold_used;
    int iss_nh[$];
    n_iss = 0; n_pv = 0; n_win = 0; t_done = -1;
    exp_addr = 0; nh = 0; hold_left = 0; hold_used = 0;
    @(negedge clk);
    start = 1'b1;
    hold  = 1'b0;
    #1;
    check("idle_busy", o_busy, 0);
    check("idle_mem_en", o_mem_en, 0);
    for (int cyc = 0; cyc < 300 && t_done < 0; cyc++) begin
      @(negedge clk);
      if (hold_len > 0 && !hold_used && exp_addr == hold_addr) begin
        hold_left = hold_len;
        hold_used = 1'b1;
      end
      hold  = (hold_left > 0);
      start = (cyc == repulse_at);
      #1;
      tag = int'(o_pix_row) * W + int'(o_pix_col);
      check("busy", o_busy, 1);
      if (hold_left > 0) begin
        check("hold_mem_en", o_mem_en, 0);
        check("hold_addr", o_mem_addr, exp_addr);
        check("hold_tag", tag, exp_addr - lat);
      end else if (n_iss < NPIX) begin
        check("issue_en", o_mem_en, 1);
        check("issue_addr", o_mem_addr, exp_addr);
        iss_nh.push_back(nh);
        exp_addr++;
        n_iss++;
      end else begin
        check("flush_mem_en", o_mem_en, 0);
      end
      check("line_shift", o_line_shift, o_pix_valid);
      if (o_pix_valid) begin
        check("pv_after_issue", n_pv < iss_nh.size(), 1);
        if (n_pv < iss_nh.size()) begin
          check("tag_order", tag, n_pv);
          check("pv_latency", nh - iss_nh[n_pv], lat);
        end
        check("win_valid", o_win_valid, (o_pix_row >= 2) && (o_pix_col >= 2));
        n_pv++;
        if (o_win_valid) n_win++;
      end else begin
        check("win_without_pv", o_win_valid, 0);
      end
      if (o_done) t_done = cyc;
      if (hold_left > 0) hold_left--;
      else nh++;
    end
    start = 1'b0;
    hold  = 1'b0;
    check("done_seen", t_done >= 0, 1);
  endtask

  task automatic frame_summary(input string tag, input int lat, input int hold_len,
                               input int n_iss, input int n_pv, input int n_win, input int t_done);
    check({tag, "_issues"},    n_iss, NPIX);
    check({tag, "_pix_valid"}, n_pv, NPIX);
    check({tag, "_win_valid"}, n_win, NWIN);
    // Issue cycles, then BRAM_LAT flush cycles, then the done cycle.
    check({tag, "_done_cycle"}, t_done, NPIX + hold_len + lat);
    @(negedge clk);
    #1;
    check({tag, "_idle_busy"}, o_busy, 0);
    check({tag, "_done_pulse"}, o_done, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n_iss, n_pv, n_win, t_done;
    n_assert = 0;
    n_fail   = 0;
    sel      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    hold     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    sel = 0;
    #1 check_reset("reset_a");
    sel = 1;
    #1 check_reset("reset_b");
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SOBEL_SEQ_CONTINUOUS_EN
    begin : cont
      int exp_addr, n_done, t_last;
      exp_addr = 0;
      n_done   = 0;
      t_last   = -1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && n_done < 3; cyc++) begin
        #1;
        check("cont_busy", o_busy, 1);
        if (o_mem_en) begin
          check("cont_addr", o_mem_addr, exp_addr % NPIX);
          exp_addr++;
        end
        if (o_done) begin
          if (n_done > 0) check("cont_period", cyc - t_last, NPIX + 2);
          else check("cont_first_done", cyc, NPIX + 1);
          t_last = cyc;
          n_done++;
        end
        @(negedge clk);
      end
      check("cont_done_count", n_done, 3);
      check("cont_issue_count", exp_addr, 3 * NPIX);
    end
`else
    sel = 0;
    run_frame(1, -1, 0, -1, n_iss, n_pv, n_win, t_done);
    frame_summary("plain", 1, 0, n_iss, n_pv, n_win, t_done);

    run_frame(1, 10, 3, -1, n_iss, n_pv, n_win, t_done);
    frame_summary("hold", 1, 3, n_iss, n_pv, n_win, t_done);

    sel = 1;
    run_frame(2, -1, 0, -1, n_iss, n_pv, n_win, t_done);
    frame_summary("lat2", 2, 0, n_iss, n_pv, n_win, t_done);

    sel = 0;
    begin : mid_reset
      bit found;
      found = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
        #1;
        if (o_mem_en && o_mem_addr == 17) found = 1'b1;
        else @(negedge clk);
      end
      check("reach_addr17", found, 1);
      #1 rst_n = 1'b0;
      #1 check_reset("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    run_frame(1, -1, 0, -1, n_iss, n_pv, n_win, t_done);
    frame_summary("post_reset", 1, 0, n_iss, n_pv, n_win, t_done);

    run_frame(1, -1, 0, 5, n_iss, n_pv, n_win, t_done);
    frame_summary("repulse", 1, 0, n_iss, n_pv, n_win, t_done);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
